router_output_arbiter: RTL and testbench
========================================

# router_output_arbiter

Per-output-port packet arbiter for the mesh router: selects which of the CHANNEL_NUMBER input channels owns one output channel. Grants are round-robin and held for a whole packet, from first beat to the TLAST beat. One instance sits beside each output port's data mux. The arbiter drives the mux select plus the valid/ready steering; the data path itself (TDATA/TID/TDEST/TUSER) is muxed outside by `grant_idx`.

## Interface
- `CHANNEL_NUMBER`, default 5: number of requesting input channels.
- `IDX_WIDTH`, default `$clog2(CHANNEL_NUMBER)`: width of `grant_idx`.
- `COUNT_WIDTH`, default 16: width of each statistics counter. Only used with `ROUTER_ARB_STATS_EN`.
- `clk`, input, 1: single clock; all state is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req_valid`, input, CHANNEL_NUMBER: bit i = input i has TVALID high and its routed destination is this output.
- `req_last`, input, CHANNEL_NUMBER: bit i = TLAST of input i.
- `out_ready`, input, 1: TREADY of the output channel.
- `out_valid`, output, 1: TVALID driven to the output channel.
- `out_last`, output, 1: TLAST driven to the output channel.
- `in_ready`, output, CHANNEL_NUMBER: TREADY contribution returned to each input for this output.
- `grant`, output, CHANNEL_NUMBER: one-hot owner; all-zero when idle.
- `grant_idx`, output, IDX_WIDTH: binary index of the owner; this is the data mux select.
- `grant_valid`, output, 1: high while the arbiter is in LOCKED.
- `pkt_count`, output, CHANNEL_NUMBER*COUNT_WIDTH: packets forwarded per input; slice i belongs to input i. Present only with `ROUTER_ARB_STATS_EN`.

## Operation
- The FSM has two states, IDLE and LOCKED.
  - Reset state is IDLE with `grant`=0 and `grant_idx`=0.
  - The priority pointer `last` resets to CHANNEL_NUMBER-1, so input 0 wins first.
- IDLE:
  - If any `req_valid` bit is set, the winner is the first set bit found searching upward from `last`+1, wrapping modulo CHANNEL_NUMBER.
  - On the next edge, register `grant`, `grant_idx` and `last` := winner, then go to LOCKED.
  - With no request, stay in IDLE.
- LOCKED:
  - Combinational outputs:
    - `out_valid` = `req_valid[grant_idx]`
    - `out_last` = `req_last[grant_idx]`
    - `in_ready[grant_idx]` = `out_ready`
    - every other `in_ready` bit = 0
  - A beat transfers when `out_valid & out_ready`.
  - A transfer with `out_last`=1 ends the packet: go to IDLE on that edge, and `grant` clears.
- In IDLE, `out_valid`=0, `out_last`=0 and `in_ready`=0.
- The grant never changes mid-packet.
  - Requests from other inputs are ignored while LOCKED.
  - If the owner drops `req_valid` mid-packet (upstream stall), the arbiter stays LOCKED.
- Round-robin property: an input that keeps requesting waits at most CHANNEL_NUMBER-1 packets.
- Single requester: it is re-granted after each packet, with one IDLE cycle between packets.
- Single-beat packet (`req_last`=1 on the first beat): enter LOCKED, transfer, return to IDLE.
- Reset asserted mid-packet: state returns asynchronously to IDLE, `grant`=0, `in_ready`=0. The partial packet is abandoned; recovery is the system's responsibility.

## Timing
- Request first seen at edge N (IDLE) gives `grant` valid after edge N, and the first beat can transfer in cycle N+1.
- Arbitration latency is therefore 1 cycle.
- Last beat transferring at edge M gives IDLE in cycle M+1 and a new grant after edge M+1.
- The per-packet bubble is therefore 1 cycle.
- Steady state: one beat per cycle while owner valid and `out_ready` are both high.
- `out_valid`, `out_last` and `in_ready` are combinational from registered grant and inputs; there is no combinational path from `out_ready` to `out_valid`.
- `grant`, `grant_idx`, `grant_valid` and `last` are registered.

## Configuration
- `ROUTER_ARB_STATS_EN` defined:
  - `pkt_count` is present.
  - Counter i increments by 1 on each transfer with `out_last`=1 while `grant_idx`=i.
  - Counters wrap modulo 2^COUNT_WIDTH and reset to 0.
- Undefined: the `pkt_count` port and its counters are absent; all other behaviour is identical.

## Test plan
- Reset with `req_valid`=00101 held:
  - after release, input 0 is granted at the first edge;
  - after its 1-beat packet, input 2 is granted;
  - then input 0 again.
- Inputs 1 and 3 each send 4-beat packets, `out_ready`=1, while input 1 is granted:
  - no grant change before input 1's TLAST beat;
  - input 3 granted exactly 1 cycle after it;
  - 4 beats, each with correct `in_ready` steering.
- `out_ready` toggles 1010 during a 3-beat packet:
  - transfers occur only on cycles where it is 1;
  - `out_last` is seen only on beat 3;
  - non-owner `in_ready` stays 0 throughout.
- Owner drops `req_valid` for 3 cycles mid-packet while input 4 requests:
  - the grant holds;
  - input 4 is granted only after the owner's TLAST.
- All 5 inputs request continuously with 2-beat packets:
  - grant order 0,1,2,3,4,0;
  - each grant lasts 2 cycles, followed by 1 idle cycle.
- `rst_n` pulsed low on beat 2 of a packet:
  - `grant`=0 and `in_ready`=0 immediately, with no clock edge needed;
  - with `ROUTER_ARB_STATS_EN`, counters read 0 and then count 1 per completed packet.

Source files
------------

// File: rtl/router_output_arbiter.sv
// router_output_arbiter: round-robin, packet-locked owner select for one router output port
// Ports: clk; rst_n async active-low; req_valid/req_last per input (TVALID-to-here, TLAST);
//   out_ready (output TREADY); out_valid/out_last (output TVALID/TLAST); in_ready per input;
//   grant one-hot owner, grant_idx data-mux select, grant_valid high while locked;
//   pkt_count per-input packet counters, present only when ROUTER_ARB_STATS_EN is defined.
module router_output_arbiter #(
  parameter int CHANNEL_NUMBER = 5,
  parameter int IDX_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int COUNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNEL_NUMBER-1:0] req_valid,
  input  logic [CHANNEL_NUMBER-1:0] req_last,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [CHANNEL_NUMBER-1:0] in_ready,
  output logic [CHANNEL_NUMBER-1:0] grant,
  output logic [IDX_WIDTH-1:0]      grant_idx,
  output logic                      grant_valid
`ifdef ROUTER_ARB_STATS_EN
  ,
  output logic [CHANNEL_NUMBER*COUNT_WIDTH-1:0] pkt_count
`endif
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [CHANNEL_NUMBER-1:0] grant_n;
  logic [IDX_WIDTH-1:0] idx_n, last, last_n, win_idx, cand;
  logic win_found, done;
  // Scan downward so the final hit is the candidate closest after last.
  always_comb begin
    win_found = 1'b0;
    win_idx = '0;
    cand = '0;
    for (int k = CHANNEL_NUMBER; k >= 1; k--) begin
      cand = IDX_WIDTH'((int'(last) + k) % CHANNEL_NUMBER);
      if (req_valid[cand]) begin
        win_found = 1'b1;
        win_idx = cand;
      end
    end
  end
  assign grant_valid = state == LOCKED;
  assign out_valid = grant_valid & req_valid[grant_idx];
  assign out_last = grant_valid & req_last[grant_idx];
  // grant is all-zero when idle, so it doubles as the ready steering mask.
  assign in_ready = {CHANNEL_NUMBER{out_ready}} & grant;
  assign done = out_valid & out_ready & out_last;
  always_comb begin
    state_n = state;
    grant_n = grant;
    idx_n = grant_idx;
    last_n = last;
    if (state == IDLE && win_found) begin
      state_n = LOCKED;
      grant_n = CHANNEL_NUMBER'(1) << win_idx;
      idx_n = win_idx;
      last_n = win_idx;
    end else if (state == LOCKED && done) begin
      state_n = IDLE;
      grant_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      grant_idx <= '0;
      last <= IDX_WIDTH'(CHANNEL_NUMBER - 1);
    end else begin
      state <= state_n;
      grant <= grant_n;
      grant_idx <= idx_n;
      last <= last_n;
    end
`ifdef ROUTER_ARB_STATS_EN
  logic [COUNT_WIDTH-1:0] cnt [CHANNEL_NUMBER];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < CHANNEL_NUMBER; k++) cnt[k] <= '0;
    end else if (done) begin
      cnt[grant_idx] <= cnt[grant_idx] + COUNT_WIDTH'(1);
    end
  for (genvar i = 0; i < CHANNEL_NUMBER; i++) begin : g_cnt
    assign pkt_count[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt[i];
  end
`endif
endmodule

// File: tb/tb_router_output_arbiter.sv
// tb_router_output_arbiter: vector table, directed corner sequences and random traffic vs a reference model
module tb_router_output_arbiter;
  localparam int N = 5;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0;
  logic out_ready = 1'b0;
  logic out_valid, out_last, grant_valid;
  logic [N-1:0] in_ready, grant;
  logic [2:0] grant_idx;
`ifdef ROUTER_ARB_STATS_EN
  logic [N*CW-1:0] pkt_count;
`endif
  int pass_cnt = 0, total = 0;
  int owner = -1, last_p = N - 1;
  int cnt [N];

  router_output_arbiter #(.CHANNEL_NUMBER(N), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .out_ready(out_ready), .out_valid(out_valid), .out_last(out_last),
    .in_ready(in_ready), .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid)
`ifdef ROUTER_ARB_STATS_EN
    , .pkt_count(pkt_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] rv, rl;
    logic rdy;
    logic [N-1:0] g, ir;
    logic ov, ol;
  } vec_t;
  vec_t tbl [19];

  function automatic vec_t v(logic [N-1:0] rv, logic [N-1:0] rl, logic rdy,
                             logic [N-1:0] g, logic [N-1:0] ir, logic ov, logic ol);
    vec_t r;
    r.rv = rv; r.rl = rl; r.rdy = rdy; r.g = g; r.ir = ir; r.ov = ov; r.ol = ol;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic mreset();
    owner = -1;
    last_p = N - 1;
    for (int i = 0; i < N; i++) cnt[i] = 0;
  endtask

  // One cycle: drive at negedge, compare against the model, then advance the model
  // to what the coming rising edge must produce.
  task automatic cycle(input logic [N-1:0] rv, input logic [N-1:0] rl, input logic rdy);
    int best, bd, d;
    logic eov, eol;
    @(negedge clk);
    req_valid = rv; req_last = rl; out_ready = rdy;
    #1;
    eov = owner >= 0 && rv[owner];
    eol = owner >= 0 && rl[owner];
    chk("m.grant", 32'(grant), owner >= 0 ? 32'd1 << owner : 32'd0);
    chk("m.grant_valid", 32'(grant_valid), 32'(owner >= 0));
    chk("m.in_ready", 32'(in_ready), (owner >= 0 && rdy) ? 32'd1 << owner : 32'd0);
    chk("m.out_valid", 32'(out_valid), 32'(eov));
    chk("m.out_last", 32'(out_last), 32'(eol));
    if (owner >= 0) chk("m.grant_idx", 32'(grant_idx), 32'(owner));
`ifdef ROUTER_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk($sformatf("m.pkt_count%0d", i), 32'(pkt_count[i*CW +: CW]), 32'(cnt[i] % (1 << CW)));
`endif
    if (owner < 0) begin
      best = -1; bd = N;
      for (int i = 0; i < N; i++)
        if (rv[i]) begin
          d = (i - last_p - 1 + 2 * N) % N;
          if (d < bd) begin bd = d; best = i; end
        end
      if (best >= 0) begin owner = best; last_p = best; end
    end else if (eov && rdy && eol) begin
      cnt[owner]++;
      owner = -1;
    end
  endtask

  task automatic rst_seq();
    @(negedge clk);
    req_valid = '0; req_last = '0; out_ready = 1'b0; rst_n = 1'b0;
    #1;
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.grant_idx", 32'(grant_idx), 32'd0);
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int beats;
    int ord [6];
    logic [N-1:0] rl;
    logic rdy;
    ord = '{0, 1, 2, 3, 4, 0};
    tbl[0]  = v(5'b00101, 5'b00101, 1'b1, 5'b00001, 5'b00001, 1'b1, 1'b1);
    tbl[1]  = v(5'b00101, 5'b00101, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0);
    tbl[2]  = v(5'b00101, 5'b00101, 1'b1, 5'b00100, 5'b00100, 1'b1, 1'b1);
    tbl[3]  = v(5'b00101, 5'b00101, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0);
    tbl[4]  = v(5'b00101, 5'b00101, 1'b1, 5'b00001, 5'b00001, 1'b1, 1'b1);
    tbl[5]  = v(5'b01010, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0);
    tbl[6]  = v(5'b01010, 5'b00000, 1'b1, 5'b00010, 5'b00010, 1'b1, 1'b0);
    tbl[7]  = v(5'b01010, 5'b00000, 1'b1, 5'b00010, 5'b00010, 1'b1, 1'b0);
    tbl[8]  = v(5'b01010, 5'b00000, 1'b1, 5'b00010, 5'b00010, 1'b1, 1'b0);
    tbl[9]  = v(5'b01010, 5'b00010, 1'b1, 5'b00010, 5'b00010, 1'b1, 1'b1);
    tbl[10] = v(5'b01000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0);
    tbl[11] = v(5'b01000, 5'b00000, 1'b1, 5'b01000, 5'b01000, 1'b1, 1'b0);
    tbl[12] = v(5'b01000, 5'b00000, 1'b1, 5'b01000, 5'b01000, 1'b1, 1'b0);
    tbl[13] = v(5'b01000, 5'b00000, 1'b1, 5'b01000, 5'b01000, 1'b1, 1'b0);
    tbl[14] = v(5'b01000, 5'b01000, 1'b1, 5'b01000, 5'b01000, 1'b1, 1'b1);
    tbl[15] = v(5'b10000, 5'b10000, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0);
    tbl[16] = v(5'b10000, 5'b10000, 1'b0, 5'b10000, 5'b00000, 1'b1, 1'b1);
    tbl[17] = v(5'b10000, 5'b10000, 1'b1, 5'b10000, 5'b10000, 1'b1, 1'b1);
    tbl[18] = v(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0);
    mreset();
    // Reset with requests 00101 held: input 0 must win at the first edge after release.
    req_valid = 5'b00101; req_last = 5'b00101; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("init.grant", 32'(grant), 32'd0);
    chk("init.grant_idx", 32'(grant_idx), 32'd0);
    chk("init.grant_valid", 32'(grant_valid), 32'd0);
    chk("init.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      req_valid = tbl[i].rv; req_last = tbl[i].rl; out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d.grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d.grant_valid", i), 32'(grant_valid), 32'(|tbl[i].g));
      chk($sformatf("tbl%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d.out_last", i), 32'(out_last), 32'(tbl[i].ol));
    end
    // out_ready toggling 1010 through a 3-beat packet from input 2 while others request.
    rst_seq();
    cycle(5'b00100, 5'b00000, 1'b1);
    beats = 0;
    for (int c = 0; c < 10 && beats < 3; c++) begin
      rdy = (c % 2) == 0;
      rl = beats == 2 ? 5'b00100 : 5'b00000;
      cycle(5'b10111, rl, rdy);
      chk("tog.out_last", 32'(out_last), 32'(beats == 2));
      chk("tog.in_ready", 32'(in_ready), rdy ? 32'b00100 : 32'd0);
      if (rdy) beats++;
    end
    chk("tog.beats", 32'(beats), 32'd3);
    cycle(5'b00000, 5'b00000, 1'b1);
    chk("tog.idle_grant", 32'(grant), 32'd0);
    // Owner stalls for 3 cycles while input 4 requests: grant must hold.
    rst_seq();
    cycle(5'b00010, 5'b00000, 1'b1);
    cycle(5'b00010, 5'b00000, 1'b1);
    repeat (3) begin
      cycle(5'b10000, 5'b00000, 1'b1);
      chk("drop.grant", 32'(grant), 32'b00010);
      chk("drop.out_valid", 32'(out_valid), 32'd0);
    end
    cycle(5'b10010, 5'b00010, 1'b1);
    chk("drop.last_grant", 32'(grant), 32'b00010);
    cycle(5'b10000, 5'b00000, 1'b1);
    chk("drop.bubble", 32'(grant), 32'd0);
    cycle(5'b10000, 5'b00000, 1'b1);
    chk("drop.next_grant", 32'(grant), 32'b10000);
    // All five inputs send 2-beat packets continuously.
    rst_seq();
    for (int k = 0; k < 18; k++) begin
      cycle(5'b11111, (k % 3) == 2 ? 5'b11111 : 5'b00000, 1'b1);
      chk($sformatf("rr%0d.grant", k), 32'(grant), (k % 3) == 0 ? 32'd0 : 32'd1 << ord[k / 3]);
    end
    // Asynchronous reset in the middle of beat 2.
    cycle(5'b00001, 5'b00000, 1'b1);
    cycle(5'b00001, 5'b00000, 1'b1);
    @(negedge clk);
    req_valid = 5'b00001; req_last = 5'b00000; out_ready = 1'b1;
    #1;
    chk("arst.pre_in_ready", 32'(in_ready), 32'b00001);
    rst_n = 1'b0;
    #1;
    chk("arst.grant", 32'(grant), 32'd0);
    chk("arst.in_ready", 32'(in_ready), 32'd0);
    chk("arst.grant_valid", 32'(grant_valid), 32'd0);
    chk("arst.out_valid", 32'(out_valid), 32'd0);
`ifdef ROUTER_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk($sformatf("arst.pkt_count%0d", i), 32'(pkt_count[i*CW +: CW]), 32'd0);
`endif
    mreset();
    @(negedge clk);
    req_valid = '0; out_ready = 1'b0; rst_n = 1'b1;
    repeat (2) begin
      cycle(5'b00001, 5'b00001, 1'b1);
      cycle(5'b00001, 5'b00001, 1'b1);
    end
    cycle(5'b00000, 5'b00000, 1'b1);
    // Random traffic against the model.
    for (int k = 0; k < 400; k++)
      cycle(N'($urandom), N'($urandom & $urandom), $urandom_range(0, 3) != 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
